// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between fetch (F) and load/store (D), one transaction in flight.
// D has priority; F is forced through after STARVE_LIMIT consecutive D wins while it waits.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    input  logic        f_flush_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_wait_oa,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic             owner_f;
    logic             drop;
    logic [CNT_W-1:0] starve_cnt;

    logic             any_req;
    logic             pick_f;
    logic             launch;
    logic             resp_done;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        any_req   = f_req_i | d_req_i;
        pick_f    = f_req_i && (!d_req_i || starve_cnt == LIMIT);
        resp_done = (state == RESP) && bus_rvalid_i;
        launch    = any_req && ((state == IDLE) || resp_done);
        cnt_next  = '0;
        // Only a D win over a waiting F counts toward starvation.
        if (f_req_i && !pick_f)
            cnt_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner_f     <= 1'b0;
            drop        <= 1'b0;
            starve_cnt  <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
        end else begin
            if (resp_done)
                drop <= 1'b0;
            else if (state != IDLE && owner_f && f_flush_i)
                drop <= 1'b1;

            case (state)
                IDLE, RESP: begin
                    if (launch) begin
                        state       <= REQ;
                        owner_f     <= pick_f;
                        starve_cnt  <= cnt_next;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= pick_f ? 1'b0 : d_we_i;
                        bus_addr_o  <= pick_f ? f_addr_i : d_addr_i;
                        bus_be_o    <= pick_f ? 4'hF : d_be_i;
                        bus_wdata_o <= pick_f ? 32'h0 : d_wdata_i;
                    end else if (resp_done) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        state     <= RESP;
                        bus_req_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush landing in the same cycle as the response also discards it.
    always_comb begin
        f_gnt_o    = (state == REQ) && owner_f && bus_gnt_i;
        d_gnt_o    = (state == REQ) && !owner_f && bus_gnt_i;
        f_rvalid_o = resp_done && owner_f && !drop && !f_flush_i;
        d_rvalid_o = resp_done && !owner_f;
        f_rdata_o  = f_rvalid_o ? bus_rdata_i : 32'h0;
        d_rdata_o  = d_rvalid_o ? bus_rdata_i : 32'h0;
        d_wait_oa  = (d_req_i | (!owner_f && state != IDLE)) & ~d_rvalid_o;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus starvation and
// reset-during-response sequences.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        fr;
        logic [31:0] fa;
        logic        ff;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [3:0]  dbe;
        logic [31:0] dwd;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        rst;
    } in_t;

    typedef struct packed {
        logic        fg;
        logic        fv;
        logic [31:0] frd;
        logic        dg;
        logic        dv;
        logic [31:0] drd;
        logic        dwait;
        logic        breq;
        logic        bwe;
        logic [31:0] baddr;
        logic [3:0]  bbe;
        logic [31:0] bwd;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic  clk = 1'b0;
    in_t   cur;
    out_t  act;
    int    tests = 0;
    int    fails = 0;
    vec_t  tbl[$];

    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, d_wait, bus_req, bus_we;
    logic [31:0] f_rdata, d_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(cur.rst),
        .f_req_i(cur.fr), .f_addr_i(cur.fa), .f_flush_i(cur.ff),
        .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
        .d_req_i(cur.dr), .d_we_i(cur.dw), .d_addr_i(cur.da), .d_be_i(cur.dbe),
        .d_wdata_i(cur.dwd), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .d_wait_oa(d_wait), .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_gnt_i(cur.g),
        .bus_rvalid_i(cur.rv), .bus_rdata_i(cur.rd)
    );

    assign act = {f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_wait,
                  bus_req, bus_we, bus_addr, bus_be, bus_wdata};

    function automatic in_t mk_in(logic fr, logic [31:0] fa, logic ff, logic dr, logic dw,
                                  logic [31:0] da, logic [3:0] dbe, logic [31:0] dwd,
                                  logic g, logic rv, logic [31:0] rd, logic rst);
        return {fr, fa, ff, dr, dw, da, dbe, dwd, g, rv, rd, rst};
    endfunction

    function automatic out_t mk_out(logic fg, logic fv, logic [31:0] frd, logic dg, logic dv,
                                    logic [31:0] drd, logic dwait, logic breq, logic bwe,
                                    logic [31:0] baddr, logic [3:0] bbe, logic [31:0] bwd);
        return {fg, fv, frd, dg, dv, drd, dwait, breq, bwe, baddr, bbe, bwd};
    endfunction

    function automatic void add(string name, in_t i, out_t o);
        vec_t v;
        v.name = name;
        v.i    = i;
        v.o    = o;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, out_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int d_before, d_after, nf;

        // Single F read
        add("reset",       mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("f_req",       mk_in(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("f_gnt",       mk_in(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h100, 'hF, 0));
        add("f_resp_wait", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h100, 'hF, 0));
        add("f_rvalid",    mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0), mk_out(0, 1, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 'h100, 'hF, 0));
        add("idle",        mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h100, 'hF, 0));
        // F and D together: D store first, F right after the D ack
        add("fd_same",     mk_in(1, 'h104, 0, 1, 1, 'h200, 'h3, 'h12345678, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h100, 'hF, 0));
        add("d_gnt_store", mk_in(1, 'h104, 0, 1, 1, 'h200, 'h3, 'h12345678, 1, 0, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 1, 1, 1, 'h200, 'h3, 'h12345678));
        add("d_resp_wait", mk_in(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h200, 'h3, 'h12345678));
        add("d_store_ack", mk_in(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 1, 'hAAAA5555, 0), mk_out(0, 0, 0, 0, 1, 'hAAAA5555, 0, 0, 1, 'h200, 'h3, 'h12345678));
        add("f_after_d",   mk_in(1, 'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h104, 'hF, 0));
        add("f_rvalid2",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 0), mk_out(0, 1, 'hCAFEF00D, 0, 0, 0, 0, 0, 0, 'h104, 'hF, 0));
        // Flush while F response outstanding
        add("f_req3",      mk_in(1, 'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h104, 'hF, 0));
        add("f_gnt3",      mk_in(1, 'h108, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h108, 'hF, 0));
        add("f_flush",     mk_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h108, 'hF, 0));
        add("f_dropped",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11111111, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h108, 'hF, 0));
        add("f_req4",      mk_in(1, 'h10C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h108, 'hF, 0));
        add("f_gnt4",      mk_in(1, 'h10C, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h10C, 'hF, 0));
        add("f_after_fl",  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h22222222, 0), mk_out(0, 1, 'h22222222, 0, 0, 0, 0, 0, 0, 'h10C, 'hF, 0));
        // D load with bus grant withheld five cycles
        add("d_load_req",  mk_in(0, 0, 0, 1, 0, 'h300, 'hF, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h10C, 'hF, 0));
        for (int k = 0; k < 5; k++)
            add($sformatf("gnt_low%0d", k), mk_in(0, 0, 0, 1, 0, 'h300, 'hF, 0, 0, 0, 0, 0),
                mk_out(0, 0, 0, 0, 0, 0, 1, 1, 0, 'h300, 'hF, 0));
        add("d_load_gnt",  mk_in(0, 0, 0, 1, 0, 'h300, 'hF, 0, 1, 0, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 1, 1, 0, 'h300, 'hF, 0));
        add("d_load_wait", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h300, 'hF, 0));
        add("d_load_data", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h33333333, 0), mk_out(0, 0, 0, 0, 1, 'h33333333, 0, 0, 0, 'h300, 'hF, 0));

        cur     = '0;
        cur.rst = 1'b1;
        repeat (2) @(posedge clk);
        foreach (tbl[n]) begin
            @(negedge clk);
            cur = tbl[n].i;
            #1;
            check(tbl[n].name, tbl[n].o);
        end

        // Starvation: both ports always requesting, bus answers at once
        d_before = 0;
        d_after  = 0;
        nf       = 0;
        for (int c = 0; c < 60 && nf < 2; c++) begin
            @(negedge clk);
            cur     = '0;
            cur.fr  = 1'b1;  cur.fa  = 32'h500;
            cur.dr  = 1'b1;  cur.da  = 32'h600;  cur.dbe = 4'hF;
            cur.g   = 1'b1;  cur.rv  = 1'b1;     cur.rd  = 32'h55;
            #1;
            if (d_gnt && nf == 0) d_before++;
            if (d_gnt && nf == 1) d_after++;
            if (f_gnt) nf++;
        end
        check_int("starve_f_grants", nf, 2);
        check_int("starve_d_before_f", d_before, 4);
        check_int("starve_d_after_clear", d_after, 4);

        @(negedge clk);
        cur = '0; cur.g = 1'b1; cur.rv = 1'b1;
        repeat (2) @(negedge clk);
        cur = '0;

        // Reset while a D load is in its response phase
        @(negedge clk);
        cur = mk_in(0, 0, 0, 1, 0, 'h400, 'hF, 0, 0, 0, 0, 0);
        @(negedge clk);
        cur = mk_in(0, 0, 0, 1, 0, 'h400, 'hF, 0, 1, 0, 0, 0);
        #1;
        check("rst_pre_gnt", mk_out(0, 0, 0, 1, 0, 0, 1, 1, 0, 'h400, 'hF, 0));
        @(negedge clk);
        cur = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check("rst_in_resp", mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h400, 'hF, 0));
        @(negedge clk);
        cur = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h44444444, 0);
        #1;
        check("rst_late_rvalid", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        cur = '0;
        #1;
        check("rst_idle", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
